// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment bus as seen by the scan decoder: the display side drives
// digit_sel/segments and the decoder returns the reconstructed value and status.
interface seg7_scan_decoder_if #(
    parameter int NDIG = 8
);
    logic [NDIG-1:0]   digit_sel;
    logic [6:0]        segments;
    logic [NDIG*4-1:0] value;
    logic              frame_valid;
    logic              bad_pattern;
    logic              bad_select;
    logic [NDIG-1:0]   digit_seen;

    modport master (
        output digit_sel, segments,
        input  value, frame_valid, bad_pattern, bad_select, digit_seen
    );

    modport slave (
        input  digit_sel, segments,
        output value, frame_valid, bad_pattern, bad_select, digit_seen
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reads back a time-multiplexed hex display: de-glitches each digit with a
// stability run counter, decodes glyphs to nibbles and publishes full frames.
module seg7_scan_decoder #(
    parameter int NDIG   = 8,
    parameter int STABLE = 3
) (
    input  logic                clock,
    input  logic                reset,
    seg7_scan_decoder_if.slave  bus
);
    localparam int SW = NDIG + 7;
    localparam logic [7:0] RUN_MAX = 8'(STABLE);
    localparam logic [7:0] RUN_CAP = 8'(STABLE - 2);

    logic [SW-1:0]     samp_reg;
    logic [7:0]        run_reg;
    logic [7:0]        run_next;
    logic [3:0]        shadow_reg [NDIG];
    logic [NDIG*4-1:0] shadow_flat;
    logic [NDIG*4-1:0] value_reg;
    logic [NDIG-1:0]   digit_seen_reg;
    logic              frame_valid_reg;
    logic              bad_pattern_reg;
    logic              bad_select_reg;

    logic [SW-1:0]   sample_in;
    logic            same;
    logic            capture;
    logic [NDIG-1:0] samp_sel;
    logic [6:0]      samp_seg;
    logic            one_hot;
    logic            legal;
    logic [3:0]      nibble;
    logic [NDIG-1:0] digit_hit;
    logic            frame_done;

    assign sample_in = {bus.digit_sel, bus.segments};
    assign same      = (sample_in == samp_reg);
    assign samp_sel  = samp_reg[SW-1:7];
    assign samp_seg  = samp_reg[6:0];
    assign one_hot   = (samp_sel != '0) && ((samp_sel & (samp_sel - 1'b1)) == '0);
    // The incoming sample matching samp is the sample that brings run to STABLE-1.
    assign capture   = same && (run_reg == RUN_CAP);
    assign frame_done = &digit_seen_reg;

    always_comb begin
        run_next = 8'd0;
        if (same) begin
            run_next = (run_reg == RUN_MAX) ? RUN_MAX : run_reg + 8'd1;
        end
    end

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        unique case (samp_seg)
            7'h3F: nibble = 4'h0;
            7'h06: nibble = 4'h1;
            7'h5B: nibble = 4'h2;
            7'h4F: nibble = 4'h3;
            7'h66: nibble = 4'h4;
            7'h6D: nibble = 4'h5;
            7'h7D: nibble = 4'h6;
            7'h07: nibble = 4'h7;
            7'h7F: nibble = 4'h8;
            7'h6F: nibble = 4'h9;
            7'h77: nibble = 4'hA;
            7'h7C: nibble = 4'hB;
            7'h39: nibble = 4'hC;
            7'h5E: nibble = 4'hD;
            7'h79: nibble = 4'hE;
            7'h71: nibble = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            samp_reg        <= '0;
            run_reg         <= 8'd0;
            value_reg       <= '0;
            frame_valid_reg <= 1'b0;
            bad_pattern_reg <= 1'b0;
            bad_select_reg  <= 1'b0;
        end else begin
            samp_reg        <= sample_in;
            run_reg         <= run_next;
            frame_valid_reg <= frame_done;
            bad_pattern_reg <= capture && one_hot && !legal;
            bad_select_reg  <= capture && !one_hot;
            if (frame_done) begin
                value_reg <= shadow_flat;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign digit_hit[gi] = capture && one_hot && legal && samp_sel[gi];
            assign shadow_flat[gi*4 +: 4] = shadow_reg[gi];

            // A completed frame restarts collection, keeping any capture from the same cycle.
            always_ff @(posedge clock) begin
                if (reset) begin
                    shadow_reg[gi]     <= 4'h0;
                    digit_seen_reg[gi] <= 1'b0;
                end else begin
                    if (digit_hit[gi]) begin
                        shadow_reg[gi] <= nibble;
                    end
                    if (frame_done) begin
                        digit_seen_reg[gi] <= digit_hit[gi];
                    end else if (digit_hit[gi]) begin
                        digit_seen_reg[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign bus.value       = value_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.bad_pattern = bad_pattern_reg;
    assign bus.bad_select  = bad_select_reg;
    assign bus.digit_seen  = digit_seen_reg;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NDIG=8, STABLE=3): scans, glitches,
// illegal glyphs, illegal selects and reset mid-frame.
module tb_seg7_scan_decoder;
    logic clock;
    logic reset;

    int n_checks;
    int n_fail;
    int fv_cnt;
    int bp_cnt;
    int bs_cnt;

    seg7_scan_decoder_if #(.NDIG(8)) bus_if ();

    seg7_scan_decoder #(.NDIG(8), .STABLE(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (bus_if.frame_valid) fv_cnt++;
        if (bus_if.bad_pattern) bp_cnt++;
        if (bus_if.bad_select)  bs_cnt++;
    end

    task automatic clear_counts();
        fv_cnt = 0;
        bp_cnt = 0;
        bs_cnt = 0;
    endtask

    // Drive a bus pattern at the current falling edge and hold it for n cycles.
    task automatic show(input logic [7:0] sel, input logic [6:0] seg, input int n);
        bus_if.digit_sel = sel;
        bus_if.segments  = seg;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        logic [7:0] sels [2];
        logic [6:0] segs [2];
        sels[0] = 8'h01; segs[0] = 7'h06;
        sels[1] = 8'h02; segs[1] = 7'h5B;
        clear_counts();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            show(sels[i], segs[i], 1);
            n_checks++;
            if (bus_if.value !== 32'h0) begin
                n_fail++; $display("FAIL reset_value cyc%0d: got %h expected 0", i, bus_if.value);
            end
            n_checks++;
            if (bus_if.digit_seen !== 8'h0) begin
                n_fail++; $display("FAIL reset_seen cyc%0d: got %h expected 0", i, bus_if.digit_seen);
            end
            n_checks++;
            if ({bus_if.frame_valid, bus_if.bad_pattern, bus_if.bad_select} !== 3'b000) begin
                n_fail++; $display("FAIL reset_pulses cyc%0d: got %b expected 000", i,
                                   {bus_if.frame_valid, bus_if.bad_pattern, bus_if.bad_select});
            end
        end
        n_checks++;
        if (fv_cnt + bp_cnt + bs_cnt !== 0) begin
            n_fail++; $display("FAIL reset_pulse_count: got %0d expected 0", fv_cnt + bp_cnt + bs_cnt);
        end
        $display("test_reset done");
        // Release with the first scan digit already on the bus.
        bus_if.digit_sel = 8'h01;
        bus_if.segments  = 7'h06;
        reset = 1'b0;
    endtask

    task automatic test_full_scan();
        logic [6:0] glyph [8];
        logic [7:0] seen_exp [8];
        glyph = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
        seen_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'h00};
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            show(8'(1 << i), glyph[i], 4);
            n_checks++;
            if (bus_if.digit_seen !== seen_exp[i]) begin
                n_fail++; $display("FAIL scan_seen digit%0d: got %h expected %h", i, bus_if.digit_seen, seen_exp[i]);
            end
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus_if.value !== 32'h87654321) begin
            n_fail++; $display("FAIL scan_value: got %h expected 87654321", bus_if.value);
        end
        n_checks++;
        if (fv_cnt !== 1) begin
            n_fail++; $display("FAIL scan_frame_count: got %0d expected 1", fv_cnt);
        end
        n_checks++;
        if (bp_cnt + bs_cnt !== 0) begin
            n_fail++; $display("FAIL scan_errors: got %0d expected 0", bp_cnt + bs_cnt);
        end
        $display("test_full_scan value=%h frames=%0d", bus_if.value, fv_cnt);
    endtask

    task automatic test_glitch();
        clear_counts();
        show(8'h04, 7'h5B, 3);
        show(8'h04, 7'h7F, 2);
        show(8'h04, 7'h5B, 4);
        show(8'h04, 7'h7F, 2);
        show(8'h04, 7'h5B, 3);
        n_checks++;
        if (bus_if.digit_seen !== 8'h04) begin
            n_fail++; $display("FAIL glitch_seen: got %h expected 04", bus_if.digit_seen);
        end
        n_checks++;
        if (bp_cnt + bs_cnt !== 0) begin
            n_fail++; $display("FAIL glitch_errors: got %0d expected 0", bp_cnt + bs_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 2) show(8'(1 << i), 7'h3F, 4);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus_if.value !== 32'h00000200) begin
            n_fail++; $display("FAIL glitch_value: got %h expected 00000200", bus_if.value);
        end
        n_checks++;
        if (fv_cnt !== 1) begin
            n_fail++; $display("FAIL glitch_frame_count: got %0d expected 1", fv_cnt);
        end
        $display("test_glitch value=%h frames=%0d", bus_if.value, fv_cnt);
    endtask

    task automatic test_bad_pattern();
        clear_counts();
        show(8'h20, 7'h00, 4);
        show(8'h20, 7'h7E, 4);
        n_checks++;
        if (bp_cnt !== 2) begin
            n_fail++; $display("FAIL badpat_count: got %0d expected 2", bp_cnt);
        end
        n_checks++;
        if (bus_if.digit_seen !== 8'h00) begin
            n_fail++; $display("FAIL badpat_seen: got %h expected 00", bus_if.digit_seen);
        end
        n_checks++;
        if (bus_if.value !== 32'h00000200 || fv_cnt !== 0) begin
            n_fail++; $display("FAIL badpat_value: got %h frames %0d expected 00000200 frames 0", bus_if.value, fv_cnt);
        end
        $display("test_bad_pattern pulses=%0d", bp_cnt);
    endtask

    task automatic test_bad_select();
        clear_counts();
        show(8'h03, 7'h06, 5);
        n_checks++;
        if (bs_cnt !== 1) begin
            n_fail++; $display("FAIL badsel_multi: got %0d expected 1", bs_cnt);
        end
        show(8'h00, 7'h06, 5);
        n_checks++;
        if (bs_cnt !== 2) begin
            n_fail++; $display("FAIL badsel_zero: got %0d expected 2", bs_cnt);
        end
        n_checks++;
        if (bus_if.digit_seen !== 8'h00 || bp_cnt !== 0) begin
            n_fail++; $display("FAIL badsel_side: got seen %h badpat %0d expected 00 and 0", bus_if.digit_seen, bp_cnt);
        end
        $display("test_bad_select pulses=%0d", bs_cnt);
    endtask

    task automatic test_reset_reverse();
        logic [6:0] glyph [8];
        glyph = '{7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 4; i++) show(8'(1 << i), 7'h06, 4);
        n_checks++;
        if (bus_if.digit_seen !== 8'h0F) begin
            n_fail++; $display("FAIL rev_partial: got %h expected 0F", bus_if.digit_seen);
        end
        reset = 1'b1;
        show(8'h80, glyph[7], 2);
        n_checks++;
        if (bus_if.digit_seen !== 8'h00 || bus_if.value !== 32'h0) begin
            n_fail++; $display("FAIL rev_reset: got seen %h value %h expected 00 and 0", bus_if.digit_seen, bus_if.value);
        end
        clear_counts();
        reset = 1'b0;
        for (int i = 7; i >= 0; i--) show(8'(1 << i), glyph[i], 4);
        repeat (2) @(negedge clock);
        n_checks++;
        if (bus_if.value !== 32'hFEDCBA98) begin
            n_fail++; $display("FAIL rev_value: got %h expected FEDCBA98", bus_if.value);
        end
        n_checks++;
        if (fv_cnt !== 1 || bus_if.digit_seen !== 8'h00) begin
            n_fail++; $display("FAIL rev_frame: got frames %0d seen %h expected 1 and 00", fv_cnt, bus_if.digit_seen);
        end
        $display("test_reset_reverse value=%h frames=%0d", bus_if.value, fv_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_counts();
        reset = 1'b1;
        bus_if.digit_sel = 8'h00;
        bus_if.segments  = 7'h00;
        repeat (2) @(negedge clock);
        test_reset();
        test_full_scan();
        test_glitch();
        test_bad_pattern();
        test_bad_select();
        test_reset_reverse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the multi-digit hex display driver. Monitors a time-multiplexed 7-segment bus (one-hot digit select plus shared segment lines) and reconstructs the hexadecimal value being shown. Each digit is de-glitched by a stability filter and decoded back to a nibble. The complete value is published once every digit has been captured. Used in benches and on-board self-check to read back what the display logic drives.

## Interface
- NDIG, 8: number of digits on the bus; value width is NDIG*4.
- STABLE, 3: consecutive identical samples required before a digit is accepted; legal range 2..255.
- clock  in  1: system clock; all logic on rising edge.
- reset  in  1: synchronous, active-high.
- digit_sel  in  NDIG: active-high one-hot digit select; bit i selects digit i, and digit 0 is the least significant nibble.
- segments  in  7: active-high segment lines; bit0=a, bit1=b … bit6=g.
- value  out  NDIG*4: last completely captured value.
- frame_valid  out  1: one-cycle pulse when value updates.
- bad_pattern  out  1: one-cycle pulse when a stable pattern is not a legal hex glyph.
- bad_select  out  1: one-cycle pulse when a stable digit_sel is not one-hot (zero or multiple bits).
- digit_seen  out  NDIG: digits captured in the current frame.

## Operation
- Input stage: `{digit_sel, segments}` is registered every cycle into `samp`.
- Run counter `run` (8 bits):
  - Cleared to 0 when `samp` differs from its previous value.
  - Otherwise increments, saturating at STABLE.
- A capture event occurs on the cycle `run` becomes STABLE-1, i.e. when the sample has held for STABLE identical samples. There is exactly one event per stable run; a held pattern never re-fires.
- On a capture event:
  - If digit_sel is not one-hot: pulse bad_select; no other effect.
  - Else, for selected digit k, decode segments (gfedcba hex) as:
    - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
    - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - Legal glyph: shadow[k] ← nibble, digit_seen[k] ← 1. A repeated digit overwrites shadow[k].
  - Any other pattern, including all-off: pulse bad_pattern; digit_seen unchanged.
- Frame completion:
  - When digit_seen would become all-ones, on the next edge: value ← shadow, frame_valid pulses, and digit_seen clears to 0.
  - A capture in that same cycle starts the new frame.
- Digit order is irrelevant; any order and any repetition are accepted.

## Timing
- Reset values: value=0, frame_valid=0, bad_pattern=0, bad_select=0, digit_seen=0. samp, run and shadow are cleared.
- Reset during a frame discards partial captures; the next frame starts from scratch. value keeps 0 until a full frame completes.
- If the inputs change to a new pattern before edge E0, the first sample of it is taken at E0:
  - shadow/digit_seen (or an error pulse) update at edge E0+STABLE-1.
  - If this completes the frame, value and frame_valid update at E0+STABLE.
- A pattern held fewer than STABLE samples is ignored entirely.
- Error pulses and frame_valid are exactly one cycle wide and are never asserted during or in the cycle after reset.

## Test plan
- Reset: assert reset 2 cycles with arbitrary bus activity → all outputs 0, no pulses.
- Full scan, NDIG=8, STABLE=3: drive digits 0..7 with glyphs 1..8 (06,5B,4F,66,6D,7D,07,7F), 4 cycles each → a single frame_valid with value=0x87654321, then digit_seen=0.
- Glitch rejection: while digit 2 shows 5B for 10 cycles, insert 2-cycle pulses of 7F → no capture of 8, no error pulses. Completing the frame gives nibble 2 = 2.
- Illegal glyph: digit 5 stable at 0x00, then 0x7E → two bad_pattern pulses, digit_seen[5] stays 0, value unchanged.
- Bad select: digit_sel=0x03 or 0x00 held 5 cycles → one bad_select pulse each, digit_seen unchanged.
- Reset mid-frame and reverse order: capture digits 0..3, then reset; scan 7..0 with F,E,d,C,b,A,9,8 → value=0xFEDCBA98, one frame_valid.
